// File: rtl/instr_sequencer.sv
// Program-memory instruction sequencer: issues stored 6-bit words over a valid/ready
// handshake, once over a programmed length or continuously in loop mode.
module instr_sequencer #(
    parameter int  PROG_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [5:0]            prog_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  loop_en,
    input  logic                  stop,
    input  logic                  instr_ready,
    output logic [5:0]            instruction,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [5:0]      mem [PROG_DEPTH];
    logic [LW-1:0]   len_q;
    logic            loop_q;
    logic [LW-1:0]   eff_len;
    logic            xfer;
    logic            last_word;

    assign eff_len   = (length > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : length;
    assign xfer      = instr_valid && instr_ready;
    assign last_word = ({1'b0, pc} == (len_q - LW'(1)));

    // Program memory is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            len_q       <= '0;
            loop_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (eff_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            len_q       <= eff_len;
                            loop_q      <= loop_en;
                            pc          <= '0;
                            instruction <= mem[0];
                            instr_valid <= 1'b1;
                            busy        <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    // stop wins over everything; a coinciding transfer was already taken by the sink.
                    if (stop) begin
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (xfer) begin
                        if (!last_word) begin
                            pc          <= pc + ADDR_WIDTH'(1);
                            instruction <= mem[pc + ADDR_WIDTH'(1)];
                        end else if (loop_q) begin
                            pc          <= '0;
                            instruction <= mem[0];
                        end else begin
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction issue unit that drives the 6-bit instruction bus of the 4-entry register-file datapath. It holds a small program memory loaded through a write port and, on `start`, issues the stored instructions in order over a valid/ready handshake, one per accepted transfer. It runs either once over a programmed length or continuously in loop mode until stopped.

## Interface
- `PROG_DEPTH`, 16: number of 6-bit program words (power of two, ≥2).
- `ADDR_WIDTH`, $clog2(PROG_DEPTH): program address width (derived; not overridden).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in ADDR_WIDTH: program write address.
- `prog_data` in 6: program word; layout [5:4] rd, [3:2] rs2, [1:0] rs1.
- `start` in 1: begin issuing; honoured only in IDLE.
- `length` in ADDR_WIDTH+1: instructions per pass, sampled at `start`; values above PROG_DEPTH are clamped to PROG_DEPTH.
- `loop_en` in 1: sampled at `start`; 1 = wrap to address 0 after the last word and keep running.
- `stop` in 1: abort/terminate while RUN.
- `instr_ready` in 1: datapath accepts `instruction` this cycle.
- `instruction` out 6: issued instruction word (registered).
- `instr_valid` out 1: `instruction` is valid (registered).
- `pc` out ADDR_WIDTH: address of the word currently presented.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on run completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `prog_we`=1 writes `prog_data` to `mem[prog_addr]` at the clock edge. `start`=1 with effective length L>0 latches L and `loop_en`, sets pc=0, loads `instruction`=mem[0] and `instr_valid`=1, then enters RUN. With `start`=1 and L=0, the block enters DONE directly and never asserts valid. If `start` and `prog_we` are high together, the write occurs and the start uses the pre-write contents of mem[0].
- RUN: a transfer occurs on any cycle with `instr_valid`&&`instr_ready`.
  - Transfer with pc<L-1: pc increments and `instruction`=mem[pc+1].
  - Transfer with pc=L-1 and loop=1: pc wraps to 0 and `instruction`=mem[0].
  - Transfer with pc=L-1 and loop=0: `instr_valid`=0 and the state moves to DONE.
  - No transfer: `instruction`, `pc` and `instr_valid` hold stable.
  - `stop`=1 in any RUN cycle: the state moves to DONE and `instr_valid`=0 on the next cycle. If a transfer coincides with `stop`, that transfer counts; any pending unaccepted word is abandoned.
- DONE: `done`=1 for exactly this cycle, then IDLE. `start` and `prog_we` are ignored in DONE.
- In RUN, `prog_we`, `start`, `length` and `loop_en` are ignored. The program memory is not reset.
- Reset (any state, including mid-run): next cycle the state is IDLE and `instruction`=0, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0. No further words issue.

## Timing
- `start` edge → `instr_valid`=1 with mem[0] in the following cycle (1-cycle latency).
- Back-to-back issue at one word per cycle while `instr_ready` is held high. There are no bubbles, including across a loop wrap.
- Last accepted transfer (non-loop) at cycle N: `instr_valid`=0 and `done`=1 at N+1, `busy`=0 at N+1, IDLE at N+2. A new `start` is honoured at N+2.
- All outputs are registered. `instr_ready` has no combinational path to any output.
- `busy` = (state==RUN). `done` never overlaps `instr_valid`.

## Test plan
- Load mem[0..3] = 6'b010001, 6'b100110, 6'b111011, 6'b000000; start with length=4, loop=0, ready tied 1 → `instruction` sequence 0x11, 0x26, 0x3B, 0x00 on 4 consecutive cycles; `done` pulses on the cycle after the last word; `busy` falls on that same cycle.
- Same program with `instr_ready` toggling 1,0,0,1,0,1,1 → each word is held stable while ready=0, no word is skipped or duplicated, and exactly 4 transfers occur.
- length=3, loop=1, ready=1 for 8 cycles, then `stop` → words 0,1,2,0,1,2,0,1 issue; `instr_valid`=0 the cycle after `stop`; `done` pulses once.
- start with length=0 → `instr_valid` stays 0; `done`=1 one cycle after `start`. With length=20 and PROG_DEPTH=16 → exactly 16 words issue.
- Mid-run `rst` after 2 transfers → next cycle all outputs are 0 and the state is IDLE. A restart issues from mem[0] with contents intact.
- `prog_we` to mem[1] during RUN → ignored, and the original mem[1] is issued. `start` during RUN → no restart.
